datapath_sequencer: RTL and testbench

//  Sequences the single-cycle register-file/ALU datapath from a command stream.
//  - Accepts one command at a time over a valid/ready handshake.
//  - Drives the datapath controls (RegDst, ALUSrc, RegWrite, op, instruction, WdataIn).
//  - Feeds ALU results back through WdataIn for write-back.
//  - Returns result and zero flag over a valid/ready response port.

---
 rtl/dp_seq_pkg.sv | 25 ++
 rtl/datapath_sequencer.sv | 138 +++++++++++++
 tb/tb_datapath_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dp_seq_pkg.sv
// Shared types and ALU op codes for the datapath sequencer.
package dp_seq_pkg;

    typedef enum logic [1:0] {
        CMD_WRITE   = 2'b00,
        CMD_ALU_R   = 2'b01,
        CMD_ALU_I   = 2'b10,
        CMD_COMPARE = 2'b11
    } cmd_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_RESP = 2'd3
    } state_e;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

endpackage

// File: rtl/datapath_sequencer.sv
// Drives a single-cycle register-file/ALU datapath from a valid/ready command
// stream and returns the ALU result over a held valid/ready response port.
module datapath_sequencer
    import dp_seq_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [3:0]         cmd_alu_op,
    input  logic [RADDR_W-1:0] cmd_rs,
    input  logic [RADDR_W-1:0] cmd_rt,
    input  logic [RADDR_W-1:0] cmd_rd,
    input  logic [15:0]        cmd_imm,
    input  logic [DATA_W-1:0]  cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_result,
    output logic               rsp_zero,
    output logic [CNT_W-1:0]   done_cnt,
    output logic               dp_RegDst,
    output logic               dp_ALUSrc,
    output logic               dp_RegWrite,
    output logic [3:0]         dp_op,
    output logic [25:0]        dp_instruction,
    output logic [DATA_W-1:0]  dp_WdataIn,
    input  logic [DATA_W-1:0]  dp_result,
    input  logic               dp_Z
);

    state_e             state_q;
    cmd_type_e          type_q;
    logic               wr_en_q;
    logic               regdst_q;
    logic               alusrc_q;
    logic               regwrite_q;
    logic [3:0]         op_q;
    logic [25:0]        instr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  result_q;
    logic               zero_q;
    logic               rsp_valid_q;
    logic [CNT_W-1:0]   done_q;

    cmd_type_e          cmd_t;
    logic               dest_nz;

    // Writes to register 0 are suppressed here rather than relying on the regfile.
    always_comb begin
        cmd_t   = cmd_type_e'(cmd_type);
        dest_nz = 1'b0;
        case (cmd_t)
            CMD_WRITE, CMD_ALU_R: dest_nz = (cmd_rd != '0);
            CMD_ALU_I:            dest_nz = (cmd_rt != '0);
            default:              dest_nz = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            type_q      <= CMD_WRITE;
            wr_en_q     <= 1'b0;
            regdst_q    <= 1'b0;
            alusrc_q    <= 1'b0;
            regwrite_q  <= 1'b0;
            op_q        <= '0;
            instr_q     <= '0;
            wdata_q     <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            done_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (cmd_valid) begin
                    type_q   <= cmd_t;
                    op_q     <= cmd_alu_op;
                    alusrc_q <= (cmd_t == CMD_ALU_I);
                    regdst_q <= (cmd_t == CMD_WRITE) || (cmd_t == CMD_ALU_R);
                    wr_en_q  <= dest_nz;
                    instr_q  <= (cmd_t == CMD_ALU_I) ? {cmd_rs, cmd_rt, cmd_imm}
                                                     : {cmd_rs, cmd_rt, cmd_rd, 11'b0};
                    if (cmd_t == CMD_WRITE) begin
                        wdata_q    <= cmd_data;
                        result_q   <= cmd_data;
                        zero_q     <= 1'b0;
                        regwrite_q <= dest_nz;
                        state_q    <= S_WB;
                    end else begin
                        state_q    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_q <= dp_result;
                    zero_q   <= dp_Z;
                    if (type_q == CMD_COMPARE) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        wdata_q    <= dp_result;
                        regwrite_q <= wr_en_q;
                        state_q    <= S_WB;
                    end
                end
                S_WB: begin
                    regwrite_q  <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    done_q      <= done_q + CNT_W'(1);
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready      = (state_q == S_IDLE);
    assign rsp_valid      = rsp_valid_q;
    assign rsp_result     = result_q;
    assign rsp_zero       = zero_q;
    assign done_cnt       = done_q;
    assign dp_RegDst      = regdst_q;
    assign dp_ALUSrc      = alusrc_q;
    assign dp_RegWrite    = regwrite_q;
    assign dp_op          = op_q;
    assign dp_instruction = instr_q;
    assign dp_WdataIn     = wdata_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Randomized bench: a register-file/ALU stub stands in for the datapath and a
// command-level model predicts results, latency, write pulses and counter.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = '0;
    logic [3:0]  cmd_alu_op = '0;
    logic [4:0]  cmd_rs = '0, cmd_rt = '0, cmd_rd = '0;
    logic [15:0] cmd_imm = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [15:0] done_cnt;
    logic        dp_RegDst, dp_ALUSrc, dp_RegWrite;
    logic [3:0]  dp_op;
    logic [25:0] dp_instruction;
    logic [31:0] dp_WdataIn, dp_result;
    logic        dp_Z;

    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] exp_done = '0;

    always #5 clk = ~clk;

    datapath_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_alu_op(cmd_alu_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .cmd_imm(cmd_imm), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .done_cnt(done_cnt),
        .dp_RegDst(dp_RegDst), .dp_ALUSrc(dp_ALUSrc), .dp_RegWrite(dp_RegWrite),
        .dp_op(dp_op), .dp_instruction(dp_instruction), .dp_WdataIn(dp_WdataIn),
        .dp_result(dp_result), .dp_Z(dp_Z)
    );

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    // Datapath stub: register file plus combinational ALU
    logic [31:0] rf [32] = '{default: 32'd0};
    logic [4:0]  f_rs, f_rt, f_rd, f_wa;
    logic [31:0] f_b;
    assign f_rs = dp_instruction[25:21];
    assign f_rt = dp_instruction[20:16];
    assign f_rd = dp_instruction[15:11];
    assign f_wa = dp_RegDst ? f_rd : f_rt;
    assign f_b  = dp_ALUSrc ? {{16{dp_instruction[15]}}, dp_instruction[15:0]} : rf[f_rt];
    assign dp_result = alu(dp_op, rf[f_rs], f_b);
    assign dp_Z      = (dp_result == 32'd0);

    always @(posedge clk)
        if (dp_RegWrite && f_wa != 5'd0) rf[f_wa] <= dp_WdataIn;

    // Reference register contents as the command stream implies
    logic [31:0] ref_rf [32] = '{default: 32'd0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] t, input logic [3:0] op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                           input logic [31:0] data, input int hold);
        logic [31:0] exp_res;
        logic [31:0] b;
        logic        exp_z, writes, dst_seen;
        logic [4:0]  dest;
        int          exp_lat, lat, pulses;
        b = (t == 2'd2) ? {{16{imm[15]}}, imm} : ref_rf[rt];
        exp_res = (t == 2'd0) ? data : alu(op, ref_rf[rs], b);
        exp_z   = (t == 2'd0) ? 1'b0 : (exp_res == 32'd0);
        dest    = (t == 2'd2) ? rt : rd;
        writes  = (t != 2'd3) && (dest != 5'd0);
        exp_lat = (t == 2'd1 || t == 2'd2) ? 3 : 2;
        pulses = 0;
        dst_seen = 1'b0;

        @(posedge clk); #1;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_type = t; cmd_alu_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
        cmd_imm = imm; cmd_data = data; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        check("alusrc", dp_ALUSrc, (t == 2'd2));
        if (dp_RegWrite) begin pulses++; dst_seen = dp_RegDst; end
        while (!rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (dp_RegWrite) begin pulses++; dst_seen = dp_RegDst; end
        end
        check("latency", lat, exp_lat);
        check("rsp_result", rsp_result, exp_res);
        check("rsp_zero", rsp_zero, exp_z);
        check("cmd_ready_busy", cmd_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (dp_RegWrite) pulses++;
            check("hold_valid", rsp_valid, 1);
            check("hold_result", rsp_result, exp_res);
            check("hold_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        #1;
        check("cmd_ready_compl", cmd_ready, 0);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (dp_RegWrite) pulses++;
        exp_done = exp_done + 16'd1;
        check("rsp_valid_drop", rsp_valid, 0);
        check("cmd_ready_back", cmd_ready, 1);
        check("done_cnt", done_cnt, exp_done);
        check("wr_pulses", pulses, writes ? 1 : 0);
        if (writes) begin
            check("regdst", dst_seen, (t != 2'd2));
            ref_rf[dest] = exp_res;
            check("rf_dest", rf[dest], ref_rf[dest]);
        end
    endtask

    logic [3:0] ops [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};

    initial begin
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_done", done_cnt, 0);
        check("rst_regwrite", dp_RegWrite, 0);
        check("rst_instr", dp_instruction, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        run_cmd(2'd0, 4'd0, 5'd0, 5'd0, 5'd1, 16'd0, 32'd40, 0);
        run_cmd(2'd0, 4'd0, 5'd0, 5'd0, 5'd2, 16'd0, 32'd20, 0);
        check("done_two", done_cnt, 2);
        run_cmd(2'd1, 4'd2, 5'd1, 5'd2, 5'd3, 16'd0, 32'd0, 0);
        check("add_60", rsp_result, 60);
        run_cmd(2'd1, 4'd6, 5'd1, 5'd2, 5'd4, 16'd0, 32'd0, 1);
        run_cmd(2'd3, 4'd6, 5'd1, 5'd1, 5'd0, 16'd0, 32'd0, 0);
        run_cmd(2'd2, 4'd2, 5'd1, 5'd5, 5'd0, 16'hFFFF, 32'd0, 0);
        check("addi_39", rf[5], 39);
        run_cmd(2'd0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 32'd5, 3);

        // Abort an ALU_R while it sits in EXEC
        @(posedge clk); #1;
        cmd_type = 2'd1; cmd_alu_op = 4'd2; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd7;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        exp_done = '0;
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_regwrite", dp_RegWrite, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_done", done_cnt, 0);
        check("abort_wdata", dp_WdataIn, 0);
        @(negedge clk) rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_rsp", rsp_valid, 0);
        end
        check("abort_no_write", rf[7], 0);
        run_cmd(2'd1, 4'd2, 5'd1, 5'd2, 5'd7, 16'd0, 32'd0, 0);

        for (int n = 0; n < 60; n++) begin
            run_cmd(2'($urandom_range(0, 3)), ops[$urandom_range(0, 5)],
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    16'($urandom), $urandom, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
